// File: rtl/module_guess_entry.sv
// Guess entry: captures Sw on Enter, emits registered (guess - secret) diff; Btn_set reprograms the secret.
// Latency: Diff/Diff_valid update 4 edges after a press is first sampled; Diff_valid lasts SHOW_CYCLES.
// No backpressure: button edges outside IDLE are dropped. Optional lockout under GUESS_LOCKOUT_EN.
module module_guess_entry #(
  parameter logic [3:0] SECRET_INIT = 4'd5,
  parameter int         SHOW_CYCLES = 8,
  parameter int         MAX_TRIES   = 3,
  parameter int         LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Sw,
  input  logic       Btn_enter,
  input  logic       Btn_set,
  output logic [4:0] Diff,
  output logic       Diff_valid,
  output logic       Match,
  output logic       Locked,
  output logic [2:0] Tries
);

  localparam int CNT_MAX = (SHOW_CYCLES > LOCK_CYCLES) ? SHOW_CYCLES : LOCK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (SHOW_CYCLES < 1 || LOCK_CYCLES < 1 || MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_bad_params
    $error("module_guess_entry: SHOW_CYCLES/LOCK_CYCLES must be >=1 and MAX_TRIES 1..7");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    SHOW = 2'd2,
    LOCK = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    secret;
  logic [3:0]    guess;
  logic [CW-1:0] cnt;

  logic enter_s1, enter_s2, enter_prev, enter_edge;
  logic set_s1, set_s2, set_prev, set_edge;

  // Edge pulses are registered so a press first sampled at edge N is seen by the FSM after edge N+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_s1   <= 1'b0;
      enter_s2   <= 1'b0;
      enter_prev <= 1'b0;
      enter_edge <= 1'b0;
      set_s1     <= 1'b0;
      set_s2     <= 1'b0;
      set_prev   <= 1'b0;
      set_edge   <= 1'b0;
    end else begin
      enter_s1   <= Btn_enter;
      enter_s2   <= enter_s1;
      enter_prev <= enter_s2;
      enter_edge <= enter_s2 & ~enter_prev;
      set_s1     <= Btn_set;
      set_s2     <= set_s1;
      set_prev   <= set_s2;
      set_edge   <= set_s2 & ~set_prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      secret     <= SECRET_INIT;
      guess      <= 4'd0;
      cnt        <= '0;
      Diff       <= 5'b10000;
      Diff_valid <= 1'b0;
      Match      <= 1'b0;
      Locked     <= 1'b0;
      Tries      <= 3'd0;
    end else begin
      Match <= 1'b0;
      case (state)
        IDLE: begin
          // Enter wins over a coincident set edge; the set edge is lost.
          if (enter_edge) begin
            guess <= Sw;
            state <= EVAL;
          end else if (set_edge) begin
            secret <= Sw;
            Tries  <= 3'd0;
          end
        end
        EVAL: begin
          Diff       <= {1'b0, guess} - {1'b0, secret};
          Diff_valid <= 1'b1;
          cnt        <= CW'(SHOW_CYCLES - 1);
          state      <= SHOW;
          if (guess == secret) begin
            Match <= 1'b1;
            Tries <= 3'd0;
          end else begin
`ifdef GUESS_LOCKOUT_EN
            Tries <= Tries + 3'd1;
`else
            Tries <= 3'd0;
`endif
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            Diff_valid <= 1'b0;
`ifdef GUESS_LOCKOUT_EN
            if (Tries == 3'(MAX_TRIES)) begin
              Locked <= 1'b1;
              cnt    <= CW'(LOCK_CYCLES - 1);
              state  <= LOCK;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef GUESS_LOCKOUT_EN
        LOCK: begin
          if (cnt == '0) begin
            Locked <= 1'b0;
            Tries  <= 3'd0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        default: begin
          Locked     <= 1'b0;
          Diff_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_guess_entry.sv
// Randomized self-checking bench for module_guess_entry against a transaction-level model.
module tb_module_guess_entry;

  localparam logic [3:0] SEC0  = 4'd5;
  localparam int         SHOW  = 8;
  localparam int         MAXT  = 3;
  localparam int         LOCKC = 16;
`ifdef GUESS_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Sw;
  logic       Btn_enter, Btn_set;
  logic [4:0] Diff;
  logic       Diff_valid, Match, Locked;
  logic [2:0] Tries;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] secret_m;
  int         tries_m;

  module_guess_entry #(
    .SECRET_INIT(SEC0),
    .SHOW_CYCLES(SHOW),
    .MAX_TRIES  (MAXT),
    .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Sw        (Sw),
    .Btn_enter (Btn_enter),
    .Btn_set   (Btn_set),
    .Diff      (Diff),
    .Diff_valid(Diff_valid),
    .Match     (Match),
    .Locked    (Locked),
    .Tries     (Tries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model: diff is plain signed subtraction wrapped to 5 bits; Tries counts consecutive misses.
  task automatic do_enter(input logic [3:0] v, input bit with_set);
    int         d, vcnt, mcnt, lcnt;
    logic [4:0] exp_diff;
    bit         hit, lockout;
    hit      = (v == secret_m);
    d        = int'(v) - int'(secret_m);
    exp_diff = 5'(d);
    if (LOCK_EN) tries_m = hit ? 0 : tries_m + 1;
    lockout = LOCK_EN && (tries_m == MAXT);

    @(posedge clk); #1;
    Sw        = v;
    Btn_enter = 1'b1;
    if (with_set) Btn_set = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("valid_before_n4", Diff_valid, 0);
    @(posedge clk); #1;
    chk("valid_at_n4", Diff_valid, 1);
    chk("diff", Diff, exp_diff);
    chk("match_at_n4", Match, hit);
    chk("tries_at_n4", Tries, tries_m);
    Btn_enter = 1'b0;
    Btn_set   = 1'b0;
    Sw        = 4'($urandom);

    vcnt = 1;
    mcnt = Match ? 1 : 0;
    lcnt = 0;
    for (int i = 0; i < SHOW + LOCKC + 8; i++) begin
      @(posedge clk); #1;
      if (Diff_valid) vcnt++;
      if (Match) mcnt++;
      if (Locked) begin
        lcnt++;
        if (lcnt == 2) Btn_enter = 1'b1;
        if (lcnt == 6) Btn_enter = 1'b0;
      end
    end
    if (lockout) tries_m = 0;
    chk("valid_cycles", vcnt, SHOW);
    chk("match_pulses", mcnt, hit);
    chk("lock_cycles", lcnt, lockout ? LOCKC : 0);
    chk("diff_hold", Diff, exp_diff);
    chk("tries_after", Tries, tries_m);
    chk("locked_after", Locked, 0);
  endtask

  task automatic do_set(input logic [3:0] v);
    @(posedge clk); #1;
    Sw      = v;
    Btn_set = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    Btn_set = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    secret_m = v;
    tries_m  = 0;
    chk("tries_after_set", Tries, 0);
    chk("valid_after_set", Diff_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    Sw        = 4'd0;
    Btn_enter = 1'b0;
    Btn_set   = 1'b0;
    secret_m  = SEC0;
    tries_m   = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_diff", Diff, 5'b10000);
    chk("rst_valid", Diff_valid, 0);
    chk("rst_locked", Locked, 0);
    chk("rst_tries", Tries, 0);
    chk("rst_match", Match, 0);

    do_enter(4'd5, 1'b0);
    do_enter(4'd7, 1'b0);
    do_enter(4'd3, 1'b0);
    do_enter(4'd15, 1'b0);

    do_set(4'd9);
    do_enter(4'd9, 1'b0);
    do_enter(4'd2, 1'b1);
    chk("secret_kept_after_both", secret_m, 9);
    do_enter(4'd9, 1'b0);

    for (int k = 0; k < 14; k++) begin
      int r;
      r = $urandom_range(0, 3);
      case (r)
        0:       do_set(4'($urandom));
        1:       do_enter(secret_m, 1'b0);
        default: do_enter(4'($urandom), bit'($urandom_range(0, 1)));
      endcase
    end

    do_set(4'd11);
    @(posedge clk); #1;
    Sw        = 4'd5;
    Btn_enter = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("mid_show_valid", Diff_valid, 1);
    Btn_enter = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("async_rst_valid", Diff_valid, 0);
    chk("async_rst_diff", Diff, 5'b10000);
    chk("async_rst_tries", Tries, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    secret_m = SEC0;
    tries_m  = 0;
    do_enter(4'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
